// File: rtl/reset_ctrl.sv
// Reset request controller: merges a debounced push-button, a software request
// and a watchdog into a stretched active-low reset request with a sticky cause.
module reset_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PULSE_CYCLES    = 8,
    parameter int WDT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 btn_ni,
    input  logic                 sw_req_i,
    input  logic                 wdt_en_i,
    input  logic                 wdt_kick_i,
    input  logic [WDT_WIDTH-1:0] wdt_limit_i,
    input  logic                 cause_clr_i,
    output logic                 rst_req_no,
    output logic [2:0]           cause_o,
    output logic                 busy_o
);

    localparam int                   DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]      DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int                   PC_W    = $clog2(PULSE_CYCLES);
    localparam logic [PC_W-1:0]      PC_LAST = PC_W'(PULSE_CYCLES - 1);
    localparam logic [WDT_WIDTH-1:0] WDT_ONE = WDT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        HOLD
    } state_t;

    state_t                 state, state_next;
    logic [PC_W-1:0]        pulse_cnt, pulse_cnt_next;
    logic [1:0]             sync_q;
    logic                   db_state;
    logic [DB_W-1:0]        db_cnt;
    logic [WDT_WIDTH-1:0]   wdt_cnt;
    logic                   idle;
    logic                   btn_event;
    logic                   wdt_fire;
    logic                   trigger;
    logic                   released;
    logic [2:0]             cause_set;
    logic                   rst_req_q;
    logic [2:0]             cause_q;

    // Button: two-flop synchronizer feeding a run-length debouncer; both idle at 1 (released).
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            db_state <= 1'b1;
            db_cnt   <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_ni};
            if (sync_q[1] == db_state) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_state <= sync_q[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign btn_event = db_state && !sync_q[1] && (db_cnt == DB_LAST);
    assign idle      = (state == IDLE);

    // A kick coincident with the limit match suppresses the event.
    assign wdt_fire = idle && wdt_en_i && !wdt_kick_i && (wdt_limit_i != '0)
                      && (wdt_cnt == wdt_limit_i - WDT_ONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_cnt <= '0;
        end else if (!idle || !wdt_en_i || wdt_kick_i || wdt_fire) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_ONE;
        end
    end

    assign trigger   = idle && (btn_event || sw_req_i || wdt_fire);
    assign released  = !sw_req_i && db_state;
    assign cause_set = trigger ? {wdt_fire, sw_req_i, btn_event} : 3'b000;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        pulse_cnt_next = pulse_cnt;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next     = ASSERT;
                    pulse_cnt_next = '0;
                end
            end
            ASSERT: begin
                if (pulse_cnt == PC_LAST) begin
                    state_next = released ? IDLE : HOLD;
                end else begin
                    pulse_cnt_next = pulse_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (released) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The request flop follows the next state so it falls on the trigger edge itself.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            rst_req_q <= 1'b1;
            cause_q   <= 3'b000;
        end else begin
            state     <= state_next;
            pulse_cnt <= pulse_cnt_next;
            rst_req_q <= (state_next == IDLE);
            cause_q   <= (cause_clr_i ? 3'b000 : cause_q) | cause_set;
        end
    end

    assign rst_req_no = rst_req_q;
    assign cause_o    = cause_q;
    assign busy_o     = !idle;

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: directed scenarios plus random stimulus, all checked
// every cycle against a behavioural model of the request/cause rules.
module tb_reset_ctrl;

    localparam int DB = 16;
    localparam int PC = 8;

    logic        clk_i       = 1'b0;
    logic        rst_ni      = 1'b0;
    logic        btn_ni      = 1'b1;
    logic        sw_req_i    = 1'b0;
    logic        wdt_en_i    = 1'b0;
    logic        wdt_kick_i  = 1'b0;
    logic [15:0] wdt_limit_i = 16'd0;
    logic        cause_clr_i = 1'b0;
    logic        rst_req_no;
    logic [2:0]  cause_o;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pulses = 0;
    logic prev_rst = 1'b1;

    reset_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES   (PC),
        .WDT_WIDTH      (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .btn_ni     (btn_ni),
        .sw_req_i   (sw_req_i),
        .wdt_en_i   (wdt_en_i),
        .wdt_kick_i (wdt_kick_i),
        .wdt_limit_i(wdt_limit_i),
        .cause_clr_i(cause_clr_i),
        .rst_req_no (rst_req_no),
        .cause_o    (cause_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Behavioural model: sample history, run lengths and "cycles low so far".
    bit       m_s1 = 1'b1, m_s2 = 1'b1;
    bit       m_db = 1'b1;
    int       m_run = 0;
    int       m_age = 0;
    bit       m_pulse = 1'b0;
    int       m_low = 0;
    bit [2:0] m_cause = 3'b000;

    task automatic model_reset();
        m_s1 = 1'b1; m_s2 = 1'b1; m_db = 1'b1; m_run = 0;
        m_age = 0; m_pulse = 1'b0; m_low = 0; m_cause = 3'b000;
    endtask

    task automatic model_step();
        bit       ev_btn, ev_wdt, rel;
        bit [2:0] set;
        rel    = !sw_req_i && m_db;
        ev_btn = 1'b0;
        ev_wdt = 1'b0;
        set    = 3'b000;
        // Debounce: the DB-th consecutive sample differing from the accepted level flips it.
        if (m_s2 == m_db) m_run = 0;
        else begin
            m_run++;
            if (m_run >= DB) begin
                m_db   = m_s2;
                m_run  = 0;
                ev_btn = (m_s2 == 1'b0);
            end
        end
        // Watchdog: fires on the L-th consecutive enabled, unkicked idle cycle.
        if (m_pulse || !wdt_en_i || wdt_kick_i) m_age = 0;
        else begin
            m_age = (m_age + 1) & 32'hFFFF;
            if (wdt_limit_i != 0 && m_age == int'(wdt_limit_i)) begin
                ev_wdt = 1'b1;
                m_age  = 0;
            end
        end
        // Pulse: at least PC cycles low, then until sw and button are both released.
        if (!m_pulse) begin
            set = {ev_wdt, sw_req_i, ev_btn};
            if (set != 3'b000) begin
                m_pulse = 1'b1;
                m_low   = 1;
            end
        end else if (m_low >= PC && rel) begin
            m_pulse = 1'b0;
        end else begin
            m_low++;
        end
        m_cause = (cause_clr_i ? 3'b000 : m_cause) | set;
        m_s2 = m_s1;
        m_s1 = btn_ni;
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) model_reset();
        else model_step();
    end

    always @(negedge clk_i) begin
        check("sb_rst_req", rst_req_no, !m_pulse);
        check("sb_busy", busy_o, m_pulse);
        check("sb_cause", cause_o, m_cause);
        if (prev_rst && !rst_req_no) n_pulses++;
        prev_rst = rst_req_no;
    end

    task automatic measure_low(output int n);
        n = 0;
        while (rst_req_no === 1'b0 && n < 1000) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    task automatic clear_cause();
        cause_clr_i = 1'b1;
        @(negedge clk_i);
        cause_clr_i = 1'b0;
        check("cause_clear", cause_o, 3'b000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, idx, base, btn_left;
        bit found;

        repeat (2) @(negedge clk_i);
        check("reset_rst_req", rst_req_no, 1'b1);
        check("reset_cause", cause_o, 3'b000);
        check("reset_busy", busy_o, 1'b0);
        #2 rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);

        // One-cycle software request: exactly PC cycles low.
        sw_req_i = 1'b1;
        @(negedge clk_i);
        sw_req_i = 1'b0;
        measure_low(n);
        check("sw_pulse_len", n, PC);
        check("sw_cause", cause_o, 3'b010);
        clear_cause();

        // Software request held 20 cycles: low for 20, rising one edge after release.
        sw_req_i = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (rst_req_no === 1'b0) n++;
        end
        sw_req_i = 1'b0;
        @(negedge clk_i);
        check("sw_hold_len", n, 20);
        check("sw_hold_release", rst_req_no, 1'b1);
        clear_cause();

        // Short button glitch: no request.
        base = n_pulses;
        btn_ni = 1'b0;
        repeat (10) @(negedge clk_i);
        btn_ni = 1'b1;
        repeat (40) @(negedge clk_i);
        check("btn_glitch_pulses", n_pulses - base, 0);

        // Stable 100-cycle press: one request, latency DB+2 edges plus one of uncertainty.
        base = n_pulses;
        found = 1'b0;
        idx = 0;
        btn_ni = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk_i);
            if (!found && rst_req_no === 1'b0) begin
                found = 1'b1;
                idx = i;
            end
        end
        btn_ni = 1'b1;
        check("btn_latency_ok", (idx >= DB + 2 && idx <= DB + 3), 1'b1);
        repeat (40) @(negedge clk_i);
        check("btn_press_pulses", n_pulses - base, 1);
        check("btn_cause", cause_o, 3'b001);
        check("btn_released", rst_req_no, 1'b1);
        clear_cause();

        // Watchdog limit 5, no kick: low after the 5th enabled edge.
        base = n_pulses;
        wdt_limit_i = 16'd5;
        wdt_en_i = 1'b1;
        idx = 0;
        for (int i = 1; i <= 20 && idx == 0; i++) begin
            @(negedge clk_i);
            if (rst_req_no === 1'b0) begin
                idx = i;
                wdt_en_i = 1'b0;
            end
        end
        wdt_en_i = 1'b0;
        check("wdt_latency", idx, 5);
        repeat (15) @(negedge clk_i);
        check("wdt_cause", cause_o, 3'b100);
        check("wdt_pulses", n_pulses - base, 1);
        clear_cause();

        // Kick every 4 cycles: never fires.
        base = n_pulses;
        wdt_en_i = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            wdt_kick_i = (i % 4 == 0);
            @(negedge clk_i);
        end
        wdt_kick_i = 1'b0;
        wdt_en_i = 1'b0;
        @(negedge clk_i);
        check("wdt_kick_pulses", n_pulses - base, 0);

        // Kick coincident with the limit match: kick wins.
        base = n_pulses;
        for (int i = 1; i <= 12; i++) begin
            wdt_en_i = (i <= 5);
            wdt_kick_i = (i == 5);
            @(negedge clk_i);
        end
        wdt_kick_i = 1'b0;
        check("wdt_kick_coincident", n_pulses - base, 0);

        // Limit 0: never fires.
        base = n_pulses;
        wdt_limit_i = 16'd0;
        wdt_en_i = 1'b1;
        repeat (300) @(negedge clk_i);
        wdt_en_i = 1'b0;
        @(negedge clk_i);
        check("wdt_limit0_pulses", n_pulses - base, 0);

        // Software and watchdog together, with a clear in the trigger cycle.
        base = n_pulses;
        wdt_limit_i = 16'd5;
        for (int i = 1; i <= 5; i++) begin
            wdt_en_i = 1'b1;
            sw_req_i = (i == 5);
            cause_clr_i = (i == 5);
            @(negedge clk_i);
        end
        wdt_en_i = 1'b0;
        sw_req_i = 1'b0;
        cause_clr_i = 1'b0;
        check("both_cause", cause_o, 3'b110);
        measure_low(n);
        check("both_pulse_len", n, PC);
        check("both_pulses", n_pulses - base, 1);
        clear_cause();

        // Second software request during ASSERT: no extension, cause unchanged.
        sw_req_i = 1'b1;
        @(negedge clk_i);
        sw_req_i = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            if (rst_req_no === 1'b0) n++;
            if (i == 3) sw_req_i = 1'b1;
            if (i == 4) sw_req_i = 1'b0;
            @(negedge clk_i);
        end
        check("retrigger_len", n, PC);
        check("retrigger_cause", cause_o, 3'b010);
        clear_cause();

        // Asynchronous reset during ASSERT.
        sw_req_i = 1'b1;
        @(negedge clk_i);
        sw_req_i = 1'b0;
        @(negedge clk_i);
        check("midrst_pre", rst_req_no, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_rst_req", rst_req_no, 1'b1);
        check("midrst_busy", busy_o, 1'b0);
        check("midrst_cause", cause_o, 3'b000);
        @(negedge clk_i);
        #2 rst_ni = 1'b1;

        // Random phase, checked cycle by cycle against the model.
        btn_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            if (btn_left == 0) begin
                btn_ni = ~btn_ni;
                btn_left = (btn_ni == 1'b0) ? int'($urandom_range(40, 1)) : int'($urandom_range(60, 1));
            end else begin
                btn_left--;
            end
            if (sw_req_i) sw_req_i = ($urandom_range(3) != 0);
            else sw_req_i = ($urandom_range(49) == 0);
            if ($urandom_range(63) == 0) wdt_en_i = ~wdt_en_i;
            wdt_kick_i = ($urandom_range(7) == 0);
            if ($urandom_range(199) == 0) wdt_limit_i = 16'($urandom_range(12));
            cause_clr_i = ($urandom_range(29) == 0);
            if ($urandom_range(499) == 0) begin
                #2 rst_ni = 1'b0;
                #1 check("rand_async_reset", rst_req_no, 1'b1);
                #3 rst_ni = 1'b1;
            end
        end

        btn_ni = 1'b1;
        sw_req_i = 1'b0;
        wdt_en_i = 1'b0;
        wdt_kick_i = 1'b0;
        cause_clr_i = 1'b0;
        repeat (60) @(negedge clk_i);
        check("final_idle", rst_req_no, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
